irq_priority_ctrl: RTL and testbench

Eight-channel interrupt controller built around the 74HC148-style priority encoding used in our combinational labs. It synchronises eight active-low request lines, latches falling edges into a pending register, and arbitrates the unmasked pending requests (fixed or rotating priority). It presents one vector at a time to a downstream consumer through an Irq/Ack handshake. It sits between raw board inputs (switches and pulses) and the sequential lab datapaths.

---
 rtl/irq_priority_ctrl.sv | 105 ++++++++++
 tb/tb_irq_priority_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_ctrl.sv
// Eight-channel interrupt controller: synchronised falling-edge capture, masked
// fixed/round-robin arbitration and an Irq/Ack handshake with a one-cycle gap.
module irq_priority_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit ROTATE      = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] Req_n,
  input  logic [7:0] Mask,
  input  logic       EI_n,
  input  logic       Ack,
  output logic       Irq,
  output logic [2:0] Vec,
  output logic [7:0] Pend,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                        state;
  logic [SYNC_STAGES-1:0][7:0]   syncStage;
  logic [7:0]                    prevReq;
  logic [7:0]                    fallEdge;
  logic [7:0]                    eligible;
  logic [7:0]                    clrMask;
  logic [2:0]                    lastGrant;
  logic [2:0]                    winner;
  logic [2:0]                    cand;

  assign fallEdge = prevReq & ~syncStage[SYNC_STAGES-1];
  assign eligible = EI_n ? 8'd0 : (Pend & ~Mask);
  assign clrMask  = (state == SERVE && Ack) ? (8'd1 << Vec) : 8'd0;

  // Later loop iterations overwrite earlier ones, so the last hit has top priority.
  always_comb begin
    winner = 3'd0;
    cand   = 3'd0;
    if (ROTATE) begin
      for (int j = 8; j >= 1; j--) begin
        cand = lastGrant - 3'(j);
        if (eligible[cand]) winner = cand;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (eligible[i]) winner = 3'(i);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      syncStage <= '1;
      prevReq   <= '1;
    end else begin
      syncStage <= {syncStage[SYNC_STAGES-2:0], Req_n};
      prevReq   <= syncStage[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      Irq       <= 1'b0;
      Vec       <= 3'd0;
      Busy      <= 1'b0;
      Pend      <= 8'd0;
      lastGrant <= 3'd0;
    end else begin
      // A fresh edge in the acknowledge cycle keeps the bit pending.
      Pend <= (Pend & ~clrMask) | fallEdge;
      case (state)
        IDLE: begin
          if (eligible != 8'd0) begin
            Vec   <= winner;
            Irq   <= 1'b1;
            Busy  <= 1'b1;
            state <= SERVE;
          end
        end
        SERVE: begin
          if (Ack) begin
            Irq   <= 1'b0;
            state <= GAP;
            if (ROTATE) lastGrant <= Vec;
          end
        end
        GAP: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Irq   <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: directed and random request batches on a fixed
// and a round-robin instance, compared against a transaction-level model.
module tb_irq_priority_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] reqN;
  logic [7:0] mask;
  logic       eiN;
  logic       ack;
  logic       useRot;
  logic       ackF, ackR;
  logic       irqF, irqR, busyF, busyR;
  logic [2:0] vecF, vecR;
  logic [7:0] pendF, pendR;
  logic       irqO, busyO;
  logic [2:0] vecO;
  logic [7:0] pendO;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] modelPend;
  logic [2:0] modelLast;
  int         grantLog[$];

  always #5 clk = ~clk;

  assign ackF  = ack & ~useRot;
  assign ackR  = ack & useRot;
  assign irqO  = useRot ? irqR  : irqF;
  assign vecO  = useRot ? vecR  : vecF;
  assign pendO = useRot ? pendR : pendF;
  assign busyO = useRot ? busyR : busyF;

  irq_priority_ctrl #(.SYNC_STAGES(2), .ROTATE(1'b0)) dutF (
    .Clk(clk), .Rst_n(rstN), .Req_n(reqN), .Mask(mask), .EI_n(eiN), .Ack(ackF),
    .Irq(irqF), .Vec(vecF), .Pend(pendF), .Busy(busyF)
  );

  irq_priority_ctrl #(.SYNC_STAGES(2), .ROTATE(1'b1)) dutR (
    .Clk(clk), .Rst_n(rstN), .Req_n(reqN), .Mask(mask), .EI_n(eiN), .Ack(ackR),
    .Irq(irqR), .Vec(vecR), .Pend(pendR), .Busy(busyR)
  );

  // Winner by rule: fixed = highest index; rotate = scan downward starting just below last grant.
  function automatic int pickWinner(input logic [7:0] elig, input logic [2:0] lastCh, input bit rot);
    if (elig == 8'd0) return -1;
    if (!rot) begin
      for (int i = 7; i >= 0; i--) if (elig[i]) return i;
    end else begin
      for (int step = 1; step <= 8; step++) begin
        int idx;
        idx = (int'(lastCh) - step + 16) % 8;
        if (elig[idx]) return idx;
      end
    end
    return -1;
  endfunction

  function automatic logic [7:0] modelElig();
    return eiN ? 8'd0 : (modelPend & ~mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Falling edge on every channel in chs; returns once Pend has captured it.
  task automatic pulse(input logic [7:0] chs);
    reqN = ~chs;
    tick();
    tick();
    reqN = 8'hFF;
    tick();
    modelPend = modelPend | chs;
  endtask

  task automatic waitIrq(output int n);
    n = 0;
    while (irqO !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("irq_seen", irqO, 1);
  endtask

  task automatic serveOne(input int expGap, output int got);
    int n;
    int w;
    waitIrq(n);
    if (expGap >= 0) check("grant_spacing", n, expGap);
    w   = pickWinner(modelElig(), modelLast, useRot);
    got = int'(vecO);
    check("vec", vecO, w);
    check("busy_serve", busyO, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    if (w >= 0) modelPend[w] = 1'b0;
    if (useRot && w >= 0) modelLast = 3'(w);
    check("irq_drop", irqO, 0);
    check("pend_after_ack", pendO, modelPend);
    grantLog.push_back(got);
    $display("[TB] grant rot=%0d vec=%0d expected=%0d wait=%0d pend=%h", useRot, got, w, n, pendO);
  endtask

  task automatic drain();
    int first;
    int v;
    first = 1;
    while (modelElig() != 8'd0) begin
      serveOne(first ? -1 : 2, v);
      first = 0;
    end
  endtask

  task automatic doReset();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    modelPend = 8'd0;
    modelLast = 3'd0;
  endtask

  task automatic randomRounds(input int rounds);
    logic [7:0] chs;
    for (int r = 0; r < rounds; r++) begin
      chs  = 8'($urandom_range(1, 255));
      mask = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
      pulse(chs);
      drain();
      check("rand_pend_masked", pendO, modelPend);
      repeat (4) tick();
      check("rand_idle_irq", irqO, 0);
      mask = 8'd0;
      drain();
      check("rand_pend_empty", pendO, 0);
    end
  endtask

  initial begin
    int n;
    int v;
    int rotSeq[6] = '{6, 4, 1, 6, 4, 1};

    rstN = 1'b0; reqN = 8'hFF; mask = 8'd0; eiN = 1'b0; ack = 1'b0; useRot = 1'b0;
    modelPend = 8'd0; modelLast = 3'd0;
    repeat (3) tick();
    rstN = 1'b1;
    repeat (5) tick();
    check("rst_irq", irqO, 0);
    check("rst_vec", vecO, 0);
    check("rst_pend", pendO, 0);
    check("rst_busy", busyO, 0);

    // Channel 5 latency: first sampled low at edge k.
    reqN = 8'hDF;
    tick(); check("lat_pend_k", pendO, 8'h00);
    tick(); check("lat_pend_k1", pendO, 8'h00);
    reqN = 8'hFF;
    tick(); check("lat_pend_k2", pendO, 8'h20); check("lat_irq_k2", irqO, 0);
    tick(); check("lat_irq_k3", irqO, 1); check("lat_vec_k3", vecO, 5); check("lat_busy", busyO, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("lat_irq_ack", irqO, 0); check("lat_pend_ack", pendO, 0); check("lat_busy_gap", busyO, 1);
    tick(); check("lat_busy_idle", busyO, 0);
    $display("[TB] latency test ch5 done");

    // Fixed priority with and without mask.
    grantLog.delete();
    pulse(8'hC4);
    drain();
    check("fixed_order0", grantLog[0], 7);
    check("fixed_order1", grantLog[1], 6);
    check("fixed_order2", grantLog[2], 2);
    grantLog.delete();
    mask = 8'h80;
    pulse(8'hC4);
    drain();
    check("mask_order0", grantLog[0], 6);
    check("mask_order1", grantLog[1], 2);
    repeat (4) tick();
    check("mask_pend_kept", pendO, 8'h80);
    check("mask_no_irq", irqO, 0);
    mask = 8'd0;
    drain();
    check("unmask_grant", grantLog[2], 7);

    // Global enable: no Irq while disabled, Ack outside SERVE ignored, no retraction.
    eiN = 1'b1;
    pulse(8'h08);
    ack = 1'b1;
    repeat (4) tick();
    ack = 1'b0;
    check("ei_no_irq", irqO, 0);
    check("ei_pend_held", pendO, 8'h08);
    eiN = 1'b0;
    waitIrq(n);
    check("ei_vec", vecO, 3);
    eiN = 1'b1;
    repeat (3) tick();
    check("ei_hold_irq", irqO, 1);
    check("ei_hold_vec", vecO, 3);
    ack = 1'b1; tick(); ack = 1'b0;
    check("ei_irq_ack", irqO, 0);
    check("ei_pend_ack", pendO, 0);
    modelPend = 8'd0;
    eiN = 1'b0;

    // Mask on the granted channel during SERVE does not retract.
    pulse(8'h10);
    waitIrq(n);
    mask = 8'h10;
    repeat (2) tick();
    check("maskvec_hold_irq", irqO, 1);
    check("maskvec_hold_vec", vecO, 4);
    ack = 1'b1; tick(); ack = 1'b0;
    check("maskvec_irq_ack", irqO, 0);
    mask = 8'd0;
    modelPend = 8'd0;

    // New edge on channel 3 coincides with its Ack: set wins.
    pulse(8'h08);
    tick();
    check("same_irq", irqO, 1);
    check("same_vec", vecO, 3);
    reqN = 8'hF7;
    tick();
    tick();
    ack = 1'b1;
    reqN = 8'hFF;
    tick();
    ack = 1'b0;
    check("same_irq_ack", irqO, 0);
    check("same_pend_kept", pendO, 8'h08);
    tick();
    tick();
    check("same_regrant_irq", irqO, 1);
    check("same_regrant_vec", vecO, 3);
    serveOne(-1, v);

    // Asynchronous reset in the middle of a handshake.
    pulse(8'h20);
    waitIrq(n);
    #2 rstN = 1'b0;
    #1;
    check("async_rst_irq", irqO, 0);
    check("async_rst_vec", vecO, 0);
    check("async_rst_pend", pendO, 0);
    check("async_rst_busy", busyO, 0);
    tick();
    rstN = 1'b1;
    modelPend = 8'd0;
    modelLast = 3'd0;
    $display("[TB] async reset test done");

    randomRounds(12);

    // Round-robin instance.
    doReset();
    useRot = 1'b1;
    pulse(8'h52);
    for (int g = 0; g < 6; g++) begin
      serveOne(-1, v);
      check("rot_seq", v, rotSeq[g]);
      if (g < 5) pulse(8'd1 << v);
    end
    drain();
    check("rot_pend_empty", pendO, 0);
    randomRounds(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
